// File: rtl/generic_elastic_staging.sv
// ---------------------------------------------------------------------------
// generic_elastic_staging
//
// Purpose: a chain of DEPTH elastic (skid-buffered) slices on a valid/ready
// stream. Each slice has one main register and one skid register, so the
// chain holds up to 2*DEPTH beats. The ready seen by each slice's upstream
// is a register output, which breaks the combinational ready path from
// out_ready back to in_ready. DEPTH=0 gives a stateless passthrough.
//
// Parameters:
//   WIDTH        payload width in bits
//   DEPTH        number of elastic slices (0 = passthrough)
//   RESET_VALUE  value loaded into every data register on reset
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   synchronous active-low reset
//   flush      in   synchronous discard of all held beats
//   in_valid   in   upstream beat present
//   in_ready   out  block accepts a beat this cycle
//   in_data    in   upstream payload
//   out_valid  out  downstream beat present
//   out_ready  in   downstream accepts a beat
//   out_data   out  downstream payload
//   occupancy  out  held-beat count; exists only when the macro
//                   GENERIC_ELASTIC_STAGING_OCC_EN is defined
// ---------------------------------------------------------------------------
module generic_elastic_staging #(
   parameter int                 WIDTH       = 8,
   parameter int                 DEPTH       = 2,
   parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
   localparam int                OCC_W       = (DEPTH == 0) ? 1 : $clog2(2*DEPTH+1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef GENERIC_ELASTIC_STAGING_OCC_EN
   ,
   output logic [OCC_W-1:0] occupancy
`endif
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign in_ready  = out_ready;
         assign out_valid = in_valid & ~flush;
         assign out_data  = in_data;
      end else begin : g_chain
         // Index i of the chain vectors is the boundary feeding slice i;
         // index DEPTH is the block output.
         logic [DEPTH:0]   vld_c;
         logic [DEPTH:0]   rdy_c;
         logic [WIDTH-1:0] dat_c [DEPTH+1];

         assign vld_c[0]     = in_valid;
         assign dat_c[0]     = in_data;
         assign rdy_c[DEPTH] = out_ready;

         for (genvar i = 0; i < DEPTH; i++) begin : g_slice
            logic             m_vld_q, m_vld_d;
            logic             s_vld_q, s_vld_d;
            logic [WIDTH-1:0] m_dat_q, m_dat_d;
            logic [WIDTH-1:0] s_dat_q, s_dat_d;
            logic             up_v;
            logic             dn_r;

            assign up_v = vld_c[i];
            assign dn_r = rdy_c[i+1];

            always_comb begin
               m_vld_d = m_vld_q;
               s_vld_d = s_vld_q;
               m_dat_d = m_dat_q;
               s_dat_d = s_dat_q;
               if (flush) begin
                  m_vld_d = 1'b0;
                  s_vld_d = 1'b0;
               end else if (!m_vld_q || dn_r) begin
                  // Main is free (or emptying this cycle): the skid holds
                  // the older beat, so it drains first. While the skid is
                  // full the upstream saw ready=0, so no new beat arrives.
                  if (s_vld_q) begin
                     m_vld_d = 1'b1;
                     m_dat_d = s_dat_q;
                     s_vld_d = 1'b0;
                  end else begin
                     m_vld_d = up_v;
                     if (up_v) m_dat_d = dat_c[i];
                  end
               end else if (up_v && !s_vld_q) begin
                  // Main stalled: catch the beat the upstream already
                  // committed to, ready drops on the next cycle.
                  s_vld_d = 1'b1;
                  s_dat_d = dat_c[i];
               end
            end

            always_ff @(posedge clk) begin
               if (!rst_n) begin
                  m_vld_q <= 1'b0;
                  s_vld_q <= 1'b0;
                  m_dat_q <= RESET_VALUE;
                  s_dat_q <= RESET_VALUE;
               end else begin
                  m_vld_q <= m_vld_d;
                  s_vld_q <= s_vld_d;
                  m_dat_q <= m_dat_d;
                  s_dat_q <= s_dat_d;
               end
            end

            // Upstream ready comes straight from the skid valid register.
            assign rdy_c[i]   = ~s_vld_q;
            assign vld_c[i+1] = m_vld_q;
            assign dat_c[i+1] = m_dat_q;
         end

         assign in_ready  = rdy_c[0] & ~flush;
         assign out_valid = vld_c[DEPTH] & ~flush;
         assign out_data  = dat_c[DEPTH];
      end
   endgenerate

`ifdef GENERIC_ELASTIC_STAGING_OCC_EN
   generate
      if (DEPTH == 0) begin : g_occ_none
         assign occupancy = '0;
      end else begin : g_occ
         logic             in_fire;
         logic             out_fire;
         logic [OCC_W-1:0] occ_q, occ_d;

         assign in_fire  = in_valid & in_ready;
         assign out_fire = out_valid & out_ready;

         always_comb begin
            occ_d = occ_q;
            if (flush) begin
               occ_d = '0;
            end else if (in_fire && !out_fire) begin
               occ_d = occ_q + OCC_W'(1);
            end else if (out_fire && !in_fire) begin
               occ_d = occ_q - OCC_W'(1);
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               occ_q <= '0;
            end else begin
               occ_q <= occ_d;
            end
         end

         assign occupancy = occ_q;
      end
   endgenerate
`endif

endmodule

// File: doc/generic_elastic_staging.md
GENERIC_ELASTIC_STAGING -- requirements
Module: generic_elastic_staging

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, payload width in bits.
REQ-002 SHALL provide parameter DEPTH, default 2, number of elastic slices; 0 = combinational passthrough.
REQ-003 SHALL provide parameter RESET_VALUE, default 0, reset value of every data register.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  synchronous discard of all held entries.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  block accepts beat this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  downstream beat present.
REQ-011 out_ready  input  1  downstream accepts beat.
REQ-012 out_data  output  WIDTH  downstream payload.
REQ-013 occupancy  output  $clog2(2*DEPTH+1)  held-beat count (present only under macro, see Configuration).

Function
REQ-014 Transfer SHALL occur on a port when valid and ready are both high at a rising edge.
REQ-015 DEPTH>=1: chain of DEPTH slices, each one main register plus one skid register with per-register valid bit; total capacity 2*DEPTH beats.
REQ-016 Each slice's upstream ready SHALL be a register output (skid register empty), never combinationally dependent on out_ready.
REQ-017 Latency in_valid accepted -> out_valid SHALL be exactly DEPTH cycles when the chain is empty and out_ready is held high.
REQ-018 Throughput SHALL be one beat per cycle with out_ready held high, no bubbles after fill.
REQ-019 Beats SHALL exit in acceptance order; no loss, duplication or reordering.
REQ-020 Slice stalled (downstream not ready, main full): incoming beat SHALL go to skid; slice ready drops next cycle.
REQ-021 Stalled slice with full skid unblocking: main SHALL present oldest beat; skid drains into main before any new beat.
REQ-022 out_data/out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 Simultaneous accept and emit in one slice SHALL keep that slice's occupancy unchanged.
REQ-024 Chain full (2*DEPTH beats): in_ready=0; in_valid ignored.
REQ-025 flush=1: all valid bits cleared at that edge; in_ready forced 0 and out_valid forced 0 during the flush cycle; in_ready returns 1 the cycle after.
REQ-026 flush and rst_n=0 together: reset behaviour SHALL take precedence.
REQ-027 Data registers SHALL load only on a transfer into them; valid-less data not cleared by flush.
REQ-028 DEPTH=0: in_ready=out_ready, out_valid=in_valid&~flush, out_data=in_data; no state.

Reset
REQ-029 rst_n=0 at a clock edge SHALL clear all valid bits and load RESET_VALUE into all data registers.
REQ-030 During and after reset: out_valid=0, out_data=RESET_VALUE, in_ready=1 (first cycle after rst_n rises), occupancy=0.
REQ-031 Reset asserted mid-transfer SHALL drop all in-flight beats; no beat emitted after reset until newly accepted.

Configuration
REQ-032 Macro GENERIC_ELASTIC_STAGING_OCC_EN defined: occupancy port present, registered count of held beats, +1 on input transfer, -1 on output transfer, unchanged on both, 0 on flush/reset.
REQ-033 Macro undefined: occupancy port and counter absent; all other behaviour identical.

Verification (WIDTH=8, DEPTH=2, RESET_VALUE=8'hA5)
REQ-034 Reset then idle -> out_valid=0, out_data=8'hA5, in_ready=1.
REQ-035 out_ready=1, send 8'h01..8'h10 back-to-back -> 8'h01 appears 2 cycles after acceptance, then one beat per cycle in order.
REQ-036 out_ready=0, offer 8'h20..8'h27 continuously -> exactly 4 accepted (8'h20..8'h23), in_ready=0, occupancy=4; raise out_ready -> 8'h20..8'h23 exit then 8'h24 onward, none lost.
REQ-037 Chain holding 3 beats, flush=1 for one cycle -> out_valid=0 next cycle, occupancy=0, no held beat ever emitted.
REQ-038 Random in_valid/out_ready at 50%, 10000 beats -> scoreboard in-order match, out_data stable under stall, occupancy never >4.
REQ-039 rst_n=0 for one cycle with 2 beats held and in_valid=1 -> no beat emitted after reset, out_data=8'hA5.
